// File: rtl/mem_req_ctrl.sv
// Valid/ready request front-end for a 16x32 single-port memory: in-order FIFO, one-cycle
// rden/wren issue, registered read response. Optional issue counters under `MEM_REQ_STATS_EN`.
module mem_req_ctrl #(
  parameter int AW    = 4,
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_data,
  output logic          mem_rden,
  output logic          mem_wren,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_datain,
  input  logic [DW-1:0] mem_dataout,
  output logic          busy,
  output logic [15:0]   rd_count,
  output logic [15:0]   wr_count
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] PTR_ONE = {{PW{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_WAIT = 2'd1,
    RESP    = 2'd2
  } state_t;

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  req_t        fifo_mem [DEPTH];
  req_t        head;
  logic [PW:0] wr_ptr;
  logic [PW:0] wr_ptr_vis;
  logic [PW:0] rd_ptr;
  logic        full;
  logic        empty;
  logic        head_avail;
  logic        push;
  logic        pop;
  state_t      state;
  state_t      state_n;
  logic        rsp_load;
  logic        rsp_clr;

  assign full       = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty      = (wr_ptr == rd_ptr);
  // The issue side sees pushes one cycle late, so a new entry never bypasses to the memory.
  assign head_avail = (wr_ptr_vis != rd_ptr);
  assign req_ready  = !full && !rst;
  assign push       = req_valid && req_ready;
  assign head       = fifo_mem[rd_ptr[PW-1:0]];
  assign busy       = !empty || (state != IDLE);

  // NOTE: the entry storage has no reset; occupancy is defined only by the pointers,
  // so stale contents are never observed and the array can map onto plain registers/RAM.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_mem[wr_ptr[PW-1:0]] <= {req_we, req_addr, req_wdata};
    end
  end

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      wr_ptr_vis <= '0;
      rd_ptr     <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      wr_ptr_vis <= wr_ptr;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    // NOTE: every signal assigned here gets a default first, so no path can infer a latch.
    state_n    = state;
    pop        = 1'b0;
    rsp_load   = 1'b0;
    rsp_clr    = 1'b0;
    mem_rden   = 1'b0;
    mem_wren   = 1'b0;
    mem_addr   = '0;
    mem_datain = '0;
    case (state)
      IDLE: begin
        if (head_avail) begin
          pop      = 1'b1;
          mem_addr = head.addr;
          if (head.we) begin
            mem_wren   = 1'b1;
            mem_datain = head.wdata;
          end else begin
            mem_rden = 1'b1;
            state_n  = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        rsp_load = 1'b1;
        state_n  = RESP;
      end
      RESP: begin
        // Issue resumes only in the cycle after the handshake.
        if (rsp_ready) begin
          rsp_clr = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else if (rsp_load) begin
      rsp_valid <= 1'b1;
      rsp_data  <= mem_dataout;
    end else if (rsp_clr) begin
      rsp_valid <= 1'b0;
    end
  end

`ifdef MEM_REQ_STATS_EN
  logic [15:0] rd_cnt;
  logic [15:0] wr_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_cnt <= '0;
      wr_cnt <= '0;
    end else begin
      if (mem_rden && (rd_cnt != 16'hFFFF)) begin
        rd_cnt <= rd_cnt + 16'd1;
      end
      if (mem_wren && (wr_cnt != 16'hFFFF)) begin
        wr_cnt <= wr_cnt + 16'd1;
      end
    end
  end

  assign rd_count = rd_cnt;
  assign wr_count = wr_cnt;
`else
  assign rd_count = 16'h0;
  assign wr_count = 16'h0;
`endif

endmodule

// File: tb/tb_mem_req_ctrl.sv
// Self-checking bench for mem_req_ctrl: directed scenarios plus randomized traffic against a
// transaction-level model (pending-request queue, golden memory image, expected-response queue).
module tb_mem_req_ctrl;

  localparam int AW    = 4;
  localparam int DW    = 32;
  localparam int DEPTH = 4;
`ifdef MEM_REQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_we = 1'b0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_data;
  logic          mem_rden;
  logic          mem_wren;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_datain;
  logic [DW-1:0] mem_dataout;
  logic          busy;
  logic [15:0]   rd_count;
  logic [15:0]   wr_count;

  mem_req_ctrl #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .mem_rden(mem_rden), .mem_wren(mem_wren), .mem_addr(mem_addr),
    .mem_datain(mem_datain), .mem_dataout(mem_dataout),
    .busy(busy), .rd_count(rd_count), .wr_count(wr_count)
  );

  always #5 clk = ~clk;

  // 16x32 single-port memory with registered read data; not affected by rst.
  logic [DW-1:0] mem_arr [16];
  always @(posedge clk) begin
    if (mem_wren) mem_arr[mem_addr] <= mem_datain;
    if (mem_rden) mem_dataout <= mem_arr[mem_addr];
  end

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } req_t;

  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            rd_n = 0;
  int            wr_n = 0;
  int            rsp_n = 0;
  int            last_wr_cyc = 0;
  int            prev_wr_cyc = 0;
  req_t          pend[$];
  logic [DW-1:0] exp_rsp[$];
  logic [DW-1:0] rsp_log[$];
  logic [DW-1:0] gold [16];
  bit            prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;

  // Scoreboard: sampled on the falling edge, mid-cycle.
  task automatic monitor();
    req_t r;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        pend.delete();
        exp_rsp.delete();
        rd_n = 0;
        wr_n = 0;
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          total++;
          if (rsp_valid !== 1'b1 || rsp_data !== prev_data) begin
            bad++;
            $display("FAIL rsp_hold: valid=%b data=%h want valid=1 data=%h", rsp_valid, rsp_data, prev_data);
          end
        end
        prev_stall = rsp_valid && !rsp_ready;
        prev_data  = rsp_data;

        total++;
        if (mem_rden === 1'b1 && mem_wren === 1'b1) begin
          bad++;
          $display("FAIL strobe_excl: rden=1 wren=1 want at most one");
        end

        if (mem_wren === 1'b1) begin
          total++;
          if (pend.size() == 0) begin
            bad++;
            $display("FAIL wr_issue: unexpected write addr=%h data=%h want none", mem_addr, mem_datain);
          end else begin
            r = pend.pop_front();
            if (!r.we || mem_addr !== r.addr || mem_datain !== r.wdata) begin
              bad++;
              $display("FAIL wr_issue: got addr=%h data=%h want we=%b addr=%h data=%h",
                       mem_addr, mem_datain, r.we, r.addr, r.wdata);
            end
            gold[r.addr] = r.wdata;
          end
          wr_n++;
          prev_wr_cyc = last_wr_cyc;
          last_wr_cyc = cyc;
        end else if (mem_rden === 1'b1) begin
          total++;
          if (pend.size() == 0) begin
            bad++;
            $display("FAIL rd_issue: unexpected read addr=%h want none", mem_addr);
          end else begin
            r = pend.pop_front();
            if (r.we || mem_addr !== r.addr) begin
              bad++;
              $display("FAIL rd_issue: got addr=%h want we=%b addr=%h", mem_addr, r.we, r.addr);
            end
            exp_rsp.push_back(gold[r.addr]);
          end
          rd_n++;
        end else begin
          total++;
          if (mem_addr !== '0 || mem_datain !== '0 || mem_rden !== 1'b0 || mem_wren !== 1'b0) begin
            bad++;
            $display("FAIL idle_bus: addr=%h datain=%h want 0 0", mem_addr, mem_datain);
          end
        end

        if (rsp_valid === 1'b1 && rsp_ready) begin
          total++;
          if (exp_rsp.size() == 0) begin
            bad++;
            $display("FAIL rsp_data: unexpected response %h want none", rsp_data);
          end else if (rsp_data !== exp_rsp[0]) begin
            bad++;
            $display("FAIL rsp_data: got %h want %h", rsp_data, exp_rsp[0]);
          end
          if (exp_rsp.size() != 0) void'(exp_rsp.pop_front());
          rsp_log.push_back(rsp_data);
          rsp_n++;
        end

        if (req_valid && req_ready === 1'b1) begin
          r.we = req_we;
          r.addr = req_addr;
          r.wdata = req_wdata;
          pend.push_back(r);
        end
      end
    end
  endtask

  // Called and returns at posedge+1; ok=0 if no handshake within the budget.
  task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d, output bit ok);
    ok = 1'b0;
    req_valid = 1'b1;
    req_we = we;
    req_addr = a;
    req_wdata = d;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      if (req_ready === 1'b1) ok = 1'b1;
      @(posedge clk);
      #1;
    end
    req_valid = 1'b0;
  endtask

  task automatic drain(output bit ok);
    rsp_ready = 1'b1;
    for (int k = 0; k < 300 && (busy !== 1'b0 || rsp_valid !== 1'b0); k++) begin
      @(posedge clk);
      #1;
    end
    ok = (busy === 1'b0 && rsp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if ({rsp_valid, mem_rden, mem_wren, busy} !== 4'b0 || rsp_data !== '0 ||
        mem_addr !== '0 || mem_datain !== '0 || rd_count !== 16'h0 || wr_count !== 16'h0) begin
      bad++;
      $display("FAIL reset_state: valid=%b rden=%b wren=%b busy=%b data=%h addr=%h din=%h rc=%h wc=%h want all 0",
               rsp_valid, mem_rden, mem_wren, busy, rsp_data, mem_addr, mem_datain, rd_count, wr_count);
    end
    rst = 1'b0;
    @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_ready: req_ready=%b want 1", req_ready);
    end
  endtask

  task automatic test_fill();
    bit ok;
    bit all_ok = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(1'b1, AW'(i), $urandom, ok);
      all_ok &= ok;
    end
    drain(ok);
    total++;
    if (!all_ok || !ok || wr_n != 16 || pend.size() != 0) begin
      bad++;
      $display("FAIL fill: accepted=%b drained=%b writes=%0d pending=%0d want 1 1 16 0", all_ok, ok, wr_n, pend.size());
    end
  endtask

  task automatic test_basic();
    bit ok;
    int w0;
    int r0;
    w0 = wr_n;
    send(1'b1, 4'd3, 32'hDEADBEEF, ok);
    drain(ok);
    total++;
    if (wr_n != w0 + 1 || last_wr_cyc == 0) begin
      bad++;
      $display("FAIL basic_wr: write strobes=%0d want 1", wr_n - w0);
    end
    r0 = rsp_n;
    send(1'b0, 4'd3, '0, ok);
    for (int k = 1; k <= 3; k++) begin
      @(posedge clk);
      #1;
      total++;
      if (rsp_valid !== (k == 3)) begin
        bad++;
        $display("FAIL read_latency: edge +%0d rsp_valid=%b want %b", k, rsp_valid, (k == 3));
      end
    end
    total++;
    if (rsp_data !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL basic_rd: rsp_data=%h want deadbeef", rsp_data);
    end
    drain(ok);
    total++;
    if (!ok || rsp_n != r0 + 1) begin
      bad++;
      $display("FAIL basic_count: drained=%b responses=%0d want 1 1", ok, rsp_n - r0);
    end
  endtask

  task automatic test_back_to_back();
    bit ok;
    int r0;
    r0 = rsp_n;
    send(1'b1, 4'd5, 32'h11111111, ok);
    send(1'b0, 4'd5, '0, ok);
    drain(ok);
    total++;
    if (!ok || rsp_n != r0 + 1 || rsp_log[rsp_log.size()-1] !== 32'h11111111) begin
      bad++;
      $display("FAIL order: responses=%0d last=%h want 1 11111111", rsp_n - r0, rsp_log[rsp_log.size()-1]);
    end
  endtask

  task automatic test_backpressure();
    bit ok;
    int r0;
    r0 = rsp_n;
    rsp_ready = 1'b0;
    send(1'b0, 4'd5, '0, ok);
    send(1'b1, 4'd2, 32'hA5A50002, ok);
    send(1'b0, 4'd2, '0, ok);
    send(1'b1, 4'd9, 32'h5A5A0009, ok);
    send(1'b0, 4'd9, '0, ok);
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1 || busy !== 1'b1 || pend.size() != DEPTH) begin
      bad++;
      $display("FAIL bp_full: ready=%b valid=%b busy=%b queued=%0d want 0 1 1 %0d",
               req_ready, rsp_valid, busy, pend.size(), DEPTH);
    end
    total++;
    if (rsp_data !== 32'h11111111) begin
      bad++;
      $display("FAIL bp_data: rsp_data=%h want 11111111", rsp_data);
    end
    rsp_ready = 1'b1;
    send(1'b1, 4'd12, 32'hC0DE000C, ok);
    drain(ok);
    total++;
    if (!ok || rsp_n != r0 + 3 || rsp_log[rsp_log.size()-2] !== 32'hA5A50002 ||
        rsp_log[rsp_log.size()-1] !== 32'h5A5A0009) begin
      bad++;
      $display("FAIL bp_drain: responses=%0d tail=%h %h want 3 a5a50002 5a5a0009",
               rsp_n - r0, rsp_log[rsp_log.size()-2], rsp_log[rsp_log.size()-1]);
    end
  endtask

  task automatic test_wrap();
    bit ok;
    send(1'b1, 4'd15, 32'd15, ok);
    send(1'b1, 4'd0, 32'd0, ok);
    send(1'b0, 4'd15, '0, ok);
    send(1'b0, 4'd0, '0, ok);
    drain(ok);
    total++;
    if (last_wr_cyc - prev_wr_cyc != 1) begin
      bad++;
      $display("FAIL wrap_rate: write gap=%0d cycles want 1", last_wr_cyc - prev_wr_cyc);
    end
    total++;
    if (!ok || rsp_log[rsp_log.size()-2] !== 32'd15 || rsp_log[rsp_log.size()-1] !== 32'd0) begin
      bad++;
      $display("FAIL wrap_data: got %h %h want 0000000f 00000000",
               rsp_log[rsp_log.size()-2], rsp_log[rsp_log.size()-1]);
    end
  endtask

  task automatic test_reset_mid();
    bit ok;
    int r0;
    logic [DW-1:0] old7;
    old7 = gold[7];
    send(1'b0, 4'd9, '0, ok);
    send(1'b1, 4'd7, ~old7, ok);
    r0 = rd_n;
    @(posedge clk);
    #1;
    total++;
    if (rd_n != r0 + 1 || rsp_valid !== 1'b0) begin
      bad++;
      $display("FAIL rst_setup: reads issued=%0d valid=%b want 1 0", rd_n - r0, rsp_valid);
    end
    rst = 1'b1;
    #1;
    total++;
    if (rsp_valid !== 1'b0 || busy !== 1'b0 || mem_wren !== 1'b0 || mem_rden !== 1'b0) begin
      bad++;
      $display("FAIL rst_mid: valid=%b busy=%b wren=%b rden=%b want 0 0 0 0", rsp_valid, busy, mem_wren, mem_rden);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
    r0 = rsp_n;
    repeat (6) @(posedge clk);
    #1;
    total++;
    if (rsp_n != r0 || rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
      bad++;
      $display("FAIL rst_drop: responses=%0d valid=%b ready=%b want 0 0 1", rsp_n - r0, rsp_valid, req_ready);
    end
    send(1'b0, 4'd7, '0, ok);
    drain(ok);
    total++;
    if (!ok || rsp_n != r0 + 1 || rsp_log[rsp_log.size()-1] !== old7) begin
      bad++;
      $display("FAIL rst_old: responses=%0d data=%h want 1 %h", rsp_n - r0, rsp_log[rsp_log.size()-1], old7);
    end
  endtask

  task automatic test_stats();
    bit ok;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    send(1'b1, 4'd1, 32'h1, ok);
    send(1'b1, 4'd2, 32'h2, ok);
    send(1'b0, 4'd1, '0, ok);
    send(1'b1, 4'd3, 32'h3, ok);
    send(1'b0, 4'd2, '0, ok);
    drain(ok);
    total++;
    if (wr_count !== (STATS ? 16'd3 : 16'd0) || rd_count !== (STATS ? 16'd2 : 16'd0)) begin
      bad++;
      $display("FAIL stats: wr_count=%0d rd_count=%0d want %0d %0d",
               wr_count, rd_count, STATS ? 3 : 0, STATS ? 2 : 0);
    end
  endtask

  task automatic test_random();
    bit ok;
    bit all_ok = 1'b1;
    bit done = 1'b0;
    int r0;
    int n_rd = 0;
    r0 = rsp_n;
    fork
      begin
        for (int i = 0; i < 80; i++) begin
          logic we;
          we = ($urandom_range(0, 1) == 1);
          if (!we) n_rd++;
          send(we, AW'($urandom_range(0, 15)), $urandom, ok);
          all_ok &= ok;
          repeat ($urandom_range(0, 2)) begin
            @(posedge clk);
            #1;
          end
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge clk);
          #1;
          rsp_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain(ok);
    total++;
    if (!all_ok || !ok || rsp_n != r0 + n_rd || pend.size() != 0 || exp_rsp.size() != 0) begin
      bad++;
      $display("FAIL random: accepted=%b drained=%b responses=%0d want %0d left=%0d/%0d",
               all_ok, ok, rsp_n - r0, n_rd, pend.size(), exp_rsp.size());
    end
    total++;
    if (rd_count !== (STATS ? 16'(rd_n) : 16'h0) || wr_count !== (STATS ? 16'(wr_n) : 16'h0)) begin
      bad++;
      $display("FAIL random_stats: rd_count=%0d wr_count=%0d want %0d %0d",
               rd_count, wr_count, STATS ? rd_n : 0, STATS ? wr_n : 0);
    end
  endtask

  initial begin
    fork
      monitor();
    join_none
    test_reset();
    test_fill();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_wrap();
    test_reset_mid();
    test_stats();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
